// File: rtl/servo_pkg.sv
// Shared servo definitions: FSM state encoding and default timing/limit constants.
package servo_pkg;

    localparam int unsigned SERVO_WIDTH   = 12;
    localparam int unsigned SERVO_PERIOD  = 3127;
    localparam int unsigned SERVO_MIN_CMP = 156;
    localparam int unsigned SERVO_MAX_CMP = 312;
    localparam int unsigned SERVO_CENTER  = 234;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLEW = 1'b1
    } servo_state_t;

endpackage

// File: rtl/servo_frame_timer.sv
// Frame counter mirroring the PWM generator: registered frame-start pulse and
// a combinational strobe for the last cycle of each frame.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int unsigned WIDTH  = SERVO_WIDTH,
    parameter int unsigned PERIOD = SERVO_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_frame_start,
    output logic o_boundary_c
);

    logic [WIDTH-1:0] r_fcnt;
    logic             r_frame_start;
    logic             w_last;

    assign w_last = (r_fcnt == WIDTH'(PERIOD - 1));

    // Count 0..PERIOD-1; frame_start is high exactly while the count is 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fcnt        <= '0;
            r_frame_start <= 1'b1;
        end else if (w_last) begin
            r_fcnt        <= '0;
            r_frame_start <= 1'b1;
        end else begin
            r_fcnt        <= r_fcnt + WIDTH'(1);
            r_frame_start <= 1'b0;
        end
    end

    assign o_frame_start = r_frame_start;
    assign o_boundary_c  = w_last;

endmodule

// File: rtl/servo_slew_ctrl.sv
// Servo position sequencer: accepts clamped targets and slews compare toward
// them by at most one step per PWM frame, updating only at frame boundaries.
module servo_slew_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned WIDTH   = SERVO_WIDTH,
    parameter int unsigned PERIOD  = SERVO_PERIOD,
    parameter int unsigned MIN_CMP = SERVO_MIN_CMP,
    parameter int unsigned MAX_CMP = SERVO_MAX_CMP,
    parameter int unsigned CENTER  = SERVO_CENTER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_pos,
    input  logic [WIDTH-1:0] tgt_step,
    input  logic             stop,
    output logic [WIDTH-1:0] compare,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DW = WIDTH + 1;

    servo_state_t     r_state;
    servo_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_compare;
    logic [WIDTH-1:0] w_compare_nxt;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] w_tgt_nxt;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] w_step_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_boundary;
    logic             w_accept;
    logic             w_arrive;
    logic [WIDTH-1:0] w_tgt_clamped;
    logic [WIDTH-1:0] w_step_eff;
    logic signed [DW-1:0] w_diff;
    logic [DW-1:0]    w_diff_abs;

    servo_frame_timer #(
        .WIDTH  (WIDTH),
        .PERIOD (PERIOD)
    ) u_frame_timer (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_frame_start (frame_start),
        .o_boundary_c  (w_boundary)
    );

    // Clamp the requested position into the legal pulse-width window.
    always_comb begin
        w_tgt_clamped = tgt_pos;
        if (tgt_pos < WIDTH'(MIN_CMP)) begin
            w_tgt_clamped = WIDTH'(MIN_CMP);
        end else if (tgt_pos > WIDTH'(MAX_CMP)) begin
            w_tgt_clamped = WIDTH'(MAX_CMP);
        end
    end

    assign w_step_eff = (tgt_step == '0) ? WIDTH'(1) : tgt_step;

    // Signed distance to target; one extra bit so any WIDTH-bit pair fits.
    assign w_diff     = $signed({1'b0, r_tgt}) - $signed({1'b0, r_compare});
    assign w_diff_abs = w_diff[DW-1] ? DW'(-w_diff) : DW'(w_diff);
    assign w_arrive   = (w_diff_abs <= {1'b0, r_step});

    assign tgt_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = tgt_valid && tgt_ready;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_compare_nxt = r_compare;
        w_tgt_nxt     = r_tgt;
        w_step_nxt    = r_step;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_tgt_nxt  = w_tgt_clamped;
                    w_step_nxt = w_step_eff;
                    if (w_tgt_clamped != r_compare) begin
                        w_state_nxt = ST_SLEW;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_SLEW: begin
                // stop wins over a boundary step in the same cycle
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_boundary) begin
                    if (w_arrive) begin
                        w_compare_nxt = r_tgt;
                        w_state_nxt   = ST_IDLE;
                        w_done_nxt    = 1'b1;
                    end else if (w_diff[DW-1]) begin
                        w_compare_nxt = r_compare - r_step;
                    end else begin
                        w_compare_nxt = r_compare + r_step;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; compare returns to CENTER with the generator reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_compare <= WIDTH'(CENTER);
            r_tgt     <= WIDTH'(CENTER);
            r_step    <= WIDTH'(1);
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_compare <= w_compare_nxt;
            r_tgt     <= w_tgt_nxt;
            r_step    <= w_step_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign compare = r_compare;
    assign busy    = (r_state == ST_SLEW);
    assign done    = r_done;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Self-checking bench for servo_slew_ctrl with a frame-level behavioural model.
module tb_servo_slew_ctrl;

    localparam int PERIOD = 3127;
    localparam int MINC   = 156;
    localparam int MAXC   = 312;
    localparam int CTR    = 234;

    logic        clk = 1'b0;
    logic        rst;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [11:0] tgt_pos;
    logic [11:0] tgt_step;
    logic        stop;
    logic [11:0] compare;
    logic        frame_start;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_fcnt, m_cmp, m_tgt, m_step;
    bit m_slew, m_done;
    int done_seen;
    logic [11:0] prev_cmp;

    always #5 clk = ~clk;

    servo_slew_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tgt_valid   (tgt_valid),
        .tgt_ready   (tgt_ready),
        .tgt_pos     (tgt_pos),
        .tgt_step    (tgt_step),
        .stop        (stop),
        .compare     (compare),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    // compare may only move in a frame_start cycle
    always @(negedge clk) begin
        if (!$isunknown(prev_cmp) && compare !== prev_cmp) begin
            n_vec++;
            if (frame_start !== 1'b1) begin
                $display("FAIL midframe_change: compare %0d -> %0d with frame_start=%0b, required frame_start=1",
                         prev_cmp, compare, frame_start);
                n_err++;
            end
        end
        prev_cmp = compare;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // one clock: sample inputs, advance model, settle 1 unit after the edge
    task automatic cyc();
        bit s_rst, s_vld, s_stop, s_bnd;
        int s_pos, s_stp, d, mag;
        s_rst  = rst;
        s_vld  = tgt_valid;
        s_stop = stop;
        s_pos  = int'(tgt_pos);
        s_stp  = int'(tgt_step);
        s_bnd  = (m_fcnt == PERIOD - 1);
        @(posedge clk);
        m_done = 0;
        if (s_rst) begin
            m_fcnt = 0; m_cmp = CTR; m_tgt = CTR; m_step = 1; m_slew = 0;
        end else begin
            if (!m_slew) begin
                if (s_vld) begin
                    m_tgt  = (s_pos < MINC) ? MINC : ((s_pos > MAXC) ? MAXC : s_pos);
                    m_step = (s_stp == 0) ? 1 : s_stp;
                    if (m_tgt != m_cmp) m_slew = 1;
                    else                m_done = 1;
                end
            end else if (s_stop) begin
                m_slew = 0;
            end else if (s_bnd) begin
                d   = m_tgt - m_cmp;
                mag = (d < 0) ? -d : d;
                if (mag <= m_step) begin
                    m_cmp = m_tgt; m_slew = 0; m_done = 1;
                end else begin
                    m_cmp = m_cmp + ((d > 0) ? m_step : -m_step);
                end
            end
            m_fcnt = (m_fcnt + 1) % PERIOD;
        end
        #1;
        if (done === 1'b1) done_seen++;
    endtask

    task automatic to_frame();
        cyc();
        while (m_fcnt != 0) cyc();
    endtask

    task automatic to_boundary();
        while (m_fcnt != PERIOD - 1) cyc();
    endtask

    // accept away from the frame edge so step timing is predictable
    task automatic accept(input int pos, input int stp, input bit with_stop);
        if (m_fcnt >= PERIOD - 20) to_frame();
        tgt_valid = 1'b1; tgt_pos = 12'(pos); tgt_step = 12'(stp); stop = with_stop;
        cyc();
        tgt_valid = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset();
        int pulses, at;
        rst = 1'b1; tgt_valid = 1'b0; stop = 1'b0; tgt_pos = '0; tgt_step = '0;
        repeat (3) cyc();
        n_vec++; if (compare !== 12'(CTR)) begin $display("FAIL reset_compare: got %0d need %0d", compare, CTR); n_err++; end
        n_vec++; if (tgt_ready !== 1'b0) begin $display("FAIL ready_in_reset: got %0b need 0", tgt_ready); n_err++; end
        rst = 1'b0;
        #1;
        n_vec++; if (tgt_ready !== 1'b1) begin $display("FAIL reset_ready: got %0b need 1", tgt_ready); n_err++; end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL reset_busy_done: got %0b/%0b need 0/0", busy, done); n_err++; end
        n_vec++; if (frame_start !== 1'b1) begin $display("FAIL first_frame_start: got %0b need 1", frame_start); n_err++; end
        pulses = 0; at = -1;
        for (int i = 1; i <= PERIOD; i++) begin
            cyc();
            if (frame_start === 1'b1) begin pulses++; if (at < 0) at = i; end
        end
        n_vec++; if (pulses != 1 || at != PERIOD) begin
            $display("FAIL frame_period: got %0d pulses first at %0d, need 1 at %0d", pulses, at, PERIOD); n_err++;
        end
    endtask

    task automatic test_equal();
        done_seen = 0;
        accept(CTR, int'($urandom_range(0, 50)), 1'b0);
        n_vec++; if (busy !== 1'b0 || done !== 1'b1) begin $display("FAIL equal_accept: busy/done %0b/%0b need 0/1", busy, done); n_err++; end
        cyc();
        n_vec++; if (done !== 1'b0) begin $display("FAIL equal_done_width: got %0b need 0", done); n_err++; end
        repeat (20) cyc();
        n_vec++; if (compare !== 12'(CTR) || done_seen != 1) begin
            $display("FAIL equal_hold: compare %0d dones %0d, need %0d and 1", compare, done_seen, CTR); n_err++;
        end
    endtask

    task automatic test_slew_300();
        int e;
        done_seen = 0;
        accept(300, 10, 1'b0);
        n_vec++; if (busy !== 1'b1) begin $display("FAIL slew_busy: got %0b need 1", busy); n_err++; end
        for (int k = 0; k < 7; k++) begin
            to_frame();
            e = (k < 6) ? 244 + 10 * k : 300;
            n_vec++; if (compare !== 12'(e) || done !== (k == 6)) begin
                $display("FAIL slew_frame%0d: compare %0d done %0b, need %0d done %0b", k, compare, done, e, (k == 6)); n_err++;
            end
        end
        cyc();
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || done_seen != 1) begin
            $display("FAIL slew_end: busy %0b done %0b dones %0d, need 0 0 1", busy, done, done_seen); n_err++;
        end
    endtask

    task automatic test_clamp();
        done_seen = 0;
        to_boundary();
        tgt_valid = 1'b1; tgt_pos = 12'(4000); tgt_step = 12'(100);
        cyc();
        tgt_valid = 1'b0;
        n_vec++; if (compare !== 12'(300) || busy !== 1'b1 || frame_start !== 1'b1) begin
            $display("FAIL boundary_accept: compare %0d busy %0b fs %0b, need 300 1 1", compare, busy, frame_start); n_err++;
        end
        to_frame();
        n_vec++; if (compare !== 12'(MAXC) || done !== 1'b1) begin
            $display("FAIL clamp_high: compare %0d done %0b, need %0d 1", compare, done, MAXC); n_err++;
        end
        accept(5, 200, 1'b0);
        to_frame();
        n_vec++; if (compare !== 12'(MINC) || done !== 1'b1 || done_seen != 2) begin
            $display("FAIL clamp_low: compare %0d done %0b dones %0d, need %0d 1 2", compare, done, done_seen, MINC); n_err++;
        end
    endtask

    task automatic test_step0();
        accept(159, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            to_frame();
            n_vec++; if (compare !== 12'(157 + k) || done !== (k == 2)) begin
                $display("FAIL step0_frame%0d: compare %0d done %0b, need %0d %0b", k, compare, done, 157 + k, (k == 2)); n_err++;
            end
        end
    endtask

    task automatic test_stop();
        done_seen = 0;
        accept(200, 5, 1'b0);
        tgt_valid = 1'b1; tgt_pos = 12'(MAXC); tgt_step = 12'(100);
        repeat (10) cyc();
        n_vec++; if (tgt_ready !== 1'b0) begin $display("FAIL busy_ready: got %0b need 0", tgt_ready); n_err++; end
        tgt_valid = 1'b0;
        to_frame();
        n_vec++; if (compare !== 12'(164)) begin $display("FAIL busy_no_accept: compare %0d need 164", compare); n_err++; end
        repeat (50) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL stop_mid: busy/done %0b/%0b need 0/0", busy, done); n_err++; end
        to_frame();
        n_vec++; if (compare !== 12'(164)) begin $display("FAIL stop_freeze: compare %0d need 164", compare); n_err++; end
        accept(200, 5, 1'b0);
        to_boundary();
        stop = 1'b1; cyc(); stop = 1'b0;
        n_vec++; if (busy !== 1'b0 || compare !== 12'(164) || frame_start !== 1'b1) begin
            $display("FAIL stop_boundary: busy %0b compare %0d fs %0b, need 0 164 1", busy, compare, frame_start); n_err++;
        end
        repeat (5) cyc();
        n_vec++; if (done_seen != 0) begin $display("FAIL stop_no_done: dones %0d need 0", done_seen); n_err++; end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1; cyc(); rst = 1'b0;
        accept(300, 36, 1'b1);
        n_vec++; if (busy !== 1'b1) begin $display("FAIL stop_with_valid_idle: busy %0b need 1", busy); n_err++; end
        to_frame();
        n_vec++; if (compare !== 12'(270)) begin $display("FAIL rst_setup: compare %0d need 270", compare); n_err++; end
        repeat (100) cyc();
        rst = 1'b1; cyc();
        n_vec++; if (compare !== 12'(CTR) || busy !== 1'b0 || frame_start !== 1'b1 || tgt_ready !== 1'b0 || done !== 1'b0) begin
            $display("FAIL rst_mid: compare %0d busy %0b fs %0b ready %0b done %0b, need %0d 0 1 0 0",
                     compare, busy, frame_start, tgt_ready, done, CTR); n_err++;
        end
        rst = 1'b0;
        #1;
        n_vec++; if (tgt_ready !== 1'b1) begin $display("FAIL rst_release_ready: got %0b need 1", tgt_ready); n_err++; end
        cyc();
        n_vec++; if (frame_start !== 1'b0) begin $display("FAIL rst_fs_width: got %0b need 0", frame_start); n_err++; end
    endtask

    task automatic test_random();
        for (int t = 0; t < 2; t++) begin
            int pos, stp, stop_at, c;
            bit bad;
            pos     = int'($urandom_range(100, 400));
            stp     = int'($urandom_range(60, 160));
            stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * PERIOD)) : -1;
            bad     = 0;
            repeat ($urandom_range(0, 50)) cyc();
            tgt_valid = 1'b1; tgt_pos = 12'(pos); tgt_step = 12'(stp);
            cyc();
            tgt_valid = 1'b0;
            c = 0;
            while (c < 4 * PERIOD && (m_slew || c == 0)) begin
                n_vec++;
                if (!bad && (compare !== 12'(m_cmp) || busy !== m_slew || done !== m_done || frame_start !== (m_fcnt == 0))) begin
                    $display("FAIL random%0d_cyc%0d: compare %0d busy %0b done %0b fs %0b, need %0d %0b %0b %0b",
                             t, c, compare, busy, done, frame_start, m_cmp, m_slew, m_done, (m_fcnt == 0));
                    n_err++; bad = 1;
                end
                c++;
                stop = (c == stop_at);
                cyc();
            end
            stop = 1'b0;
            n_vec++;
            if (compare !== 12'(m_cmp) || busy !== m_slew || done !== m_done) begin
                $display("FAIL random%0d_end: compare %0d busy %0b done %0b, need %0d %0b %0b",
                         t, compare, busy, done, m_cmp, m_slew, m_done);
                n_err++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_slew_300();
        test_clamp();
        test_step0();
        test_stop();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
